// File: rtl/adc_capture_pkg.sv
// Shared types and default sizing for the ADC capture block.
package adc_capture_pkg;

  // Default sample width, FIFO depth and run-length counter width.
  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int LEN_W_DEF      = 16;

  // Number of flops used to bring clk_ad into the mclk domain. One more
  // flop sits behind these for rising-edge detection.
  localparam int SYNC_STAGES = 2;

  // Capture controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } cap_state_t;

endpackage

// File: rtl/adc_capture_sync_fifo.sv
// Small first-word-fall-through FIFO. The head word is visible on rdata
// whenever the FIFO is not empty; rdata reads as zero when it is empty so
// that downstream outputs have a defined value after reset.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Full and empty come straight from the registered occupancy, so a push
  // that arrives while full is refused even if a pop happens that cycle.
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array; contents are only meaningful between the pointers, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture.sv
// ADC sample capture: brings clk_ad-paced samples into the mclk domain,
// frames a run of programmed length behind an optional level trigger,
// buffers the run in a FIFO and streams it out with an end-of-run marker.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              clk_ad,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [LEN_W-1:0]  cap_len,
  output logic [DATA_W-1:0] s_data,
  output logic              s_last,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Synchronizer and sample path
  logic [SYNC_STAGES:0] sync_q;
  logic [DATA_W-1:0]    data_q;
  logic                 rise;
  logic                 samp_stb_q;
  logic [DATA_W-1:0]    sample_q;

  // Controller state
  cap_state_t        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              take;
  logic              is_last;

  // FIFO interface
  logic [DATA_W:0]   fifo_wdata;
  logic [DATA_W:0]   fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;

  // The top synchronizer stage is the settled copy of clk_ad; the flop
  // behind it holds the previous value, so their difference marks a rise.
  assign rise = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

  // clk_ad synchronizer, ADC bus register and registered sample strobe.
  // The sample is grabbed from data_q at the rise, well inside the window
  // where the converter holds its bus stable.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      data_q     <= '0;
      samp_stb_q <= 1'b0;
      sample_q   <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-1:0], clk_ad};
      data_q     <= ad_data;
      samp_stb_q <= rise;
      if (rise) begin
        sample_q <= data_q;
      end
    end
  end

  // The sample being taken is the final one of the run when the counter
  // has reached one below the programmed length.
  assign is_last = (cnt_q == (len_q - 1'b1));

  // Controller next-state logic. "take" means the current strobe belongs to
  // the run (either the triggering sample or any sample during CAPTURE);
  // taken samples always advance the counter, even when the FIFO is full and
  // the sample itself has to be dropped, so the run length in time is kept.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          len_d   = cap_len;
          level_d = trig_level;
          cnt_d   = '0;
          prev_d  = '0;
          ovf_d   = 1'b0;
          if (cap_len == '0) begin
            done_d = 1'b1;
          end else if (trig_en) begin
            state_d = ARMED;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      ARMED: begin
        if (samp_stb_q) begin
          prev_d = sample_q;
          if ((prev_q < level_q) && (sample_q >= level_q)) begin
            take = 1'b1;
          end
        end
      end
      CAPTURE: begin
        take = samp_stb_q;
      end
      DRAIN: begin
        if (fifo_empty || ((fifo_count == CNT_W'(1)) && pop)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (take) begin
      cnt_d = cnt_q + 1'b1;
      if (fifo_full) begin
        ovf_d = 1'b1;
      end
      if (is_last) begin
        state_d = DRAIN;
      end else if (state_q == ARMED) begin
        state_d = CAPTURE;
      end
    end
  end

  // Controller registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign fifo_wdata = {sample_q, is_last};
  assign pop        = s_valid & s_ready;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (mclk),
    .rst_n (rst_n),
    .push  (take),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign s_valid  = ~fifo_empty;
  assign s_data   = fifo_rdata[DATA_W:1];
  assign s_last   = fifo_rdata[0];
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
